// File: rtl/dual_port_ram_arbiter_pkg.sv
// Shared helpers for the dual-port RAM arbiter: modular index stepping used by
// both the round-robin picker and the pointer update.
package dual_port_ram_arbiter_pkg;

    function automatic int wrap_index(int base, int offset, int modulus);
        return (base + offset) % modulus;
    endfunction

endpackage

// File: rtl/dual_port_ram_arbiter_picker.sv
// Combinational round-robin picker: scans clients from the pointer and returns
// up to two grants, skipping port-1 candidates that conflict with the port-0 winner.
module round_robin_dual_picker
    import dual_port_ram_arbiter_pkg::*;
#(
    parameter int REQUESTERS  = 4,
    parameter int INDEX_WIDTH = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0]            valid,
    input  logic [INDEX_WIDTH-1:0]           pointer,
    input  logic [REQUESTERS*REQUESTERS-1:0] conflict,
    output logic [INDEX_WIDTH-1:0]           index_0,
    output logic [INDEX_WIDTH-1:0]           index_1,
    output logic                             grant_0,
    output logic                             grant_1
);

    logic [INDEX_WIDTH-1:0] candidate;

    // Bit a*REQUESTERS+b of conflict means clients a and b cannot share a cycle.
    always_comb begin
        index_0   = '0;
        index_1   = '0;
        grant_0   = 1'b0;
        grant_1   = 1'b0;
        candidate = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            candidate = INDEX_WIDTH'(wrap_index(int'(pointer), k, REQUESTERS));
            if (valid[candidate]) begin
                if (!grant_0) begin
                    grant_0 = 1'b1;
                    index_0 = candidate;
                end else if (!grant_1 &&
                             !conflict[int'(index_0)*REQUESTERS + int'(candidate)]) begin
                    grant_1 = 1'b1;
                    index_1 = candidate;
                end
            end
        end
    end

endmodule

// File: rtl/dual_port_ram_arbiter.sv
// Front-end scheduler for an external true dual-port RAM: round-robin grants to two ports
// and read-data routing. `DUAL_PORT_RAM_ARBITER_READ_WRITE_COLLISION_BLOCK_EN also blocks read/write same-address pairs.
module dual_port_ram_arbiter
    import dual_port_ram_arbiter_pkg::*;
#(
    parameter int REQUESTERS    = 4,
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int READ_LATENCY  = 1,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int INDEX_WIDTH   = $clog2(REQUESTERS)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [REQUESTERS-1:0]           request_valid,
    output logic [REQUESTERS-1:0]           request_ready,
    input  logic [REQUESTERS-1:0]           request_write,
    input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] request_address,
    input  logic [REQUESTERS*WIDTH-1:0]     request_write_data,
    output logic [REQUESTERS-1:0]           response_valid,
    output logic [REQUESTERS*WIDTH-1:0]     response_data,
    output logic                            port_0_access_enable,
    output logic                            port_0_write,
    output logic [ADDRESS_WIDTH-1:0]        port_0_address,
    output logic [WIDTH-1:0]                port_0_write_data,
    input  logic [WIDTH-1:0]                port_0_read_data,
    output logic                            port_1_access_enable,
    output logic                            port_1_write,
    output logic [ADDRESS_WIDTH-1:0]        port_1_address,
    output logic [WIDTH-1:0]                port_1_write_data,
    input  logic [WIDTH-1:0]                port_1_read_data
);

    logic [INDEX_WIDTH-1:0]           pointer;
    logic [REQUESTERS*REQUESTERS-1:0] conflict;
    logic [INDEX_WIDTH-1:0]           index_0, index_1;
    logic                             grant_0, grant_1;
    logic                             live_0, live_1;
    logic                             read_0, read_1;
    logic                             slot_valid_0, slot_valid_1;
    logic [INDEX_WIDTH-1:0]           slot_index_0, slot_index_1;

    always_comb begin
        conflict = '0;
        for (int a = 0; a < REQUESTERS; a++) begin
            for (int b = 0; b < REQUESTERS; b++) begin
                if (a != b && request_address[a*ADDRESS_WIDTH +: ADDRESS_WIDTH] ==
                              request_address[b*ADDRESS_WIDTH +: ADDRESS_WIDTH]) begin
`ifdef DUAL_PORT_RAM_ARBITER_READ_WRITE_COLLISION_BLOCK_EN
                    conflict[a*REQUESTERS + b] = request_write[a] | request_write[b];
`else
                    conflict[a*REQUESTERS + b] = request_write[a] & request_write[b];
`endif
                end
            end
        end
    end

    round_robin_dual_picker #(
        .REQUESTERS (REQUESTERS),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) picker (
        .valid   (request_valid),
        .pointer (pointer),
        .conflict(conflict),
        .index_0 (index_0),
        .index_1 (index_1),
        .grant_0 (grant_0),
        .grant_1 (grant_1)
    );

    assign live_0 = grant_0 & ~reset;
    assign live_1 = grant_1 & ~reset;
    assign read_0 = live_0 & ~request_write[index_0];
    assign read_1 = live_1 & ~request_write[index_1];

    always_comb begin
        request_ready = '0;
        if (live_0) request_ready[index_0] = 1'b1;
        if (live_1) request_ready[index_1] = 1'b1;
    end

    assign port_0_access_enable = live_0;
    assign port_0_write         = live_0 & request_write[index_0];
    assign port_0_address       = live_0 ? request_address[int'(index_0)*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;
    assign port_0_write_data    = live_0 ? request_write_data[int'(index_0)*WIDTH +: WIDTH] : '0;
    assign port_1_access_enable = live_1;
    assign port_1_write         = live_1 & request_write[index_1];
    assign port_1_address       = live_1 ? request_address[int'(index_1)*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;
    assign port_1_write_data    = live_1 ? request_write_data[int'(index_1)*WIDTH +: WIDTH] : '0;

    // Resume the scan just past the last client served so each pair moves on.
    always_ff @(posedge clock) begin
        if (reset) begin
            pointer <= '0;
        end else if (grant_0) begin
            pointer <= INDEX_WIDTH'(wrap_index(int'(grant_1 ? index_1 : index_0), 1, REQUESTERS));
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_registered
            logic                   read_q_0, read_q_1;
            logic [INDEX_WIDTH-1:0] route_0, route_1;

            always_ff @(posedge clock) begin
                if (reset) begin
                    read_q_0 <= 1'b0;
                    read_q_1 <= 1'b0;
                    route_0  <= '0;
                    route_1  <= '0;
                end else begin
                    read_q_0 <= read_0;
                    read_q_1 <= read_1;
                    route_0  <= index_0;
                    route_1  <= index_1;
                end
            end

            // Gated by reset so a read in flight when reset rises is dropped at once.
            assign slot_valid_0 = read_q_0 & ~reset;
            assign slot_valid_1 = read_q_1 & ~reset;
            assign slot_index_0 = route_0;
            assign slot_index_1 = route_1;
        end else begin : g_combinational
            assign slot_valid_0 = read_0;
            assign slot_valid_1 = read_1;
            assign slot_index_0 = index_0;
            assign slot_index_1 = index_1;
        end
    endgenerate

    // The two ports always serve distinct clients, so the slots never overlap.
    always_comb begin
        response_valid = '0;
        response_data  = '0;
        if (slot_valid_0) begin
            response_valid[slot_index_0] = 1'b1;
            response_data[int'(slot_index_0)*WIDTH +: WIDTH] = port_0_read_data;
        end
        if (slot_valid_1) begin
            response_valid[slot_index_1] = 1'b1;
            response_data[int'(slot_index_1)*WIDTH +: WIDTH] = port_1_read_data;
        end
    end

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Bench for dual_port_ram_arbiter (REQUESTERS=4, WIDTH=8, DEPTH=16, READ_LATENCY=1) with a
// behavioural dual-port RAM; expected read data comes from a shadow memory via a scoreboard queue.
module tb_dual_port_ram_arbiter;

    localparam int R  = 4;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           preload;
    logic [R-1:0]   request_valid, request_ready, request_write, response_valid;
    logic [R*AW-1:0] request_address;
    logic [R*W-1:0] request_write_data, response_data;
    logic           p0_en, p0_we, p1_en, p1_we;
    logic [AW-1:0]  p0_a, p1_a;
    logic [W-1:0]   p0_wd, p1_wd, p0_rd, p1_rd;

    logic [W-1:0]   mem    [0:D-1];
    logic [W-1:0]   shadow [0:D-1];

    typedef struct {
        int         due;
        int         client;
        logic [W-1:0] data;
        bit         care;
    } rsp_t;

    rsp_t sb[$];
    int   cycle_n = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    always #5 clock = ~clock;

    dual_port_ram_arbiter #(
        .REQUESTERS(R), .WIDTH(W), .DEPTH(D), .READ_LATENCY(1)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .request_valid       (request_valid),
        .request_ready       (request_ready),
        .request_write       (request_write),
        .request_address     (request_address),
        .request_write_data  (request_write_data),
        .response_valid      (response_valid),
        .response_data       (response_data),
        .port_0_access_enable(p0_en),
        .port_0_write        (p0_we),
        .port_0_address      (p0_a),
        .port_0_write_data   (p0_wd),
        .port_0_read_data    (p0_rd),
        .port_1_access_enable(p1_en),
        .port_1_write        (p1_we),
        .port_1_address      (p1_a),
        .port_1_write_data   (p1_wd),
        .port_1_read_data    (p1_rd)
    );

    function automatic logic [W-1:0] init_val(int i);
        return W'(i * 17 + 3);
    endfunction

    // External RAM with registered read; not cleared by the arbiter's reset.
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < D; i++) mem[i] <= init_val(i);
        end else begin
            if (p0_en) begin
                if (p0_we) mem[p0_a] <= p0_wd;
                else       p0_rd     <= mem[p0_a];
            end
            if (p1_en) begin
                if (p1_we) mem[p1_a] <= p1_wd;
                else       p1_rd     <= mem[p1_a];
            end
        end
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, want %0h", tag, cycle_n, obs, exp);
        end
    endtask

    task automatic check_rsp();
        logic [R-1:0]   exp_v;
        logic [R*W-1:0] exp_d, mask;
        rsp_t           e;
        exp_v = '0;
        exp_d = '0;
        mask  = '1;
        while (sb.size() > 0 && sb[0].due == cycle_n) begin
            e = sb.pop_front();
            exp_v[e.client] = 1'b1;
            if (e.care) exp_d[e.client*W +: W] = e.data;
            else        mask[e.client*W +: W]  = '0;
        end
        chk("rsp_valid", 64'(response_valid), 64'(exp_v));
        chk("rsp_data", 64'(response_data & mask), 64'(exp_d));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cycle_n++;
        check_rsp();
        @(negedge clock);
    endtask

    // Drive one cycle of requests, check the grant, and advance the shadow model.
    task automatic apply(string tag, logic [R-1:0] v, logic [R-1:0] wr, logic [R*AW-1:0] addr,
                         logic [R*W-1:0] wd, logic [R-1:0] exp_ready, bit care);
        request_valid      = v;
        request_write      = wr;
        request_address    = addr;
        request_write_data = wd;
        #1;
        chk({tag, " ready"}, 64'(request_ready), 64'(exp_ready));
        chk({tag, " en0"}, 64'(p0_en), 64'(exp_ready != '0));
        chk({tag, " en1"}, 64'(p1_en), 64'($countones(exp_ready) == 2));
        if ($countones(exp_ready) < 2) chk({tag, " idle addr1"}, 64'(p1_a), 64'(0));
        for (int i = 0; i < R; i++)
            if (exp_ready[i] && !wr[i])
                sb.push_back('{due: cycle_n + 1, client: i, data: shadow[addr[i*AW +: AW]], care: care});
        for (int i = 0; i < R; i++)
            if (exp_ready[i] && wr[i]) shadow[addr[i*AW +: AW]] = wd[i*W +: W];
    endtask

    localparam logic [R*AW-1:0] RR_ADDR = {4'd11, 4'd10, 4'd9, 4'd8};

    initial begin
        for (int i = 0; i < D; i++) shadow[i] = init_val(i);
        preload            = 1'b1;
        reset              = 1'b1;
        request_valid      = 4'b1111;
        request_write      = '0;
        request_address    = RR_ADDR;
        request_write_data = '0;
        @(negedge clock);
        @(negedge clock);
        preload = 1'b0;

        #1;
        chk("reset ready", 64'(request_ready), 64'(0));
        chk("reset en0", 64'(p0_en), 64'(0));
        chk("reset en1", 64'(p1_en), 64'(0));
        chk("reset rsp_valid", 64'(response_valid), 64'(0));
        tick();
        reset = 1'b0;

        apply("rr0", 4'b1111, 4'b0000, RR_ADDR, '0, 4'b0011, 1'b1); tick();
        apply("rr1", 4'b1111, 4'b0000, RR_ADDR, '0, 4'b1100, 1'b1); tick();
        apply("rr2", 4'b1111, 4'b0000, RR_ADDR, '0, 4'b0011, 1'b1); tick();
        apply("rr3", 4'b1111, 4'b0000, RR_ADDR, '0, 4'b1100, 1'b1); tick();

        apply("wr_a5", 4'b0100, 4'b0100, {4'd0, 4'd3, 4'd0, 4'd0}, {8'h00, 8'hA5, 8'h00, 8'h00}, 4'b0100, 1'b1); tick();
        apply("rd_a5", 4'b0001, 4'b0000, {4'd0, 4'd0, 4'd0, 4'd3}, '0, 4'b0001, 1'b1); tick();

        apply("ww", 4'b1010, 4'b1010, {4'd7, 4'd0, 4'd7, 4'd0}, {8'h73, 8'h00, 8'h71, 8'h00}, 4'b0010, 1'b1); tick();
        apply("ww2", 4'b1000, 4'b1000, {4'd7, 4'd0, 4'd0, 4'd0}, {8'h73, 8'h00, 8'h00, 8'h00}, 4'b1000, 1'b1); tick();
        apply("rd7", 4'b0001, 4'b0000, {4'd0, 4'd0, 4'd0, 4'd7}, '0, 4'b0001, 1'b1); tick();

        apply("w11", 4'b0010, 4'b0010, {4'd0, 4'd0, 4'd5, 4'd0}, {8'h00, 8'h00, 8'h11, 8'h00}, 4'b0010, 1'b1); tick();
`ifdef DUAL_PORT_RAM_ARBITER_READ_WRITE_COLLISION_BLOCK_EN
        apply("rw", 4'b0011, 4'b0001, {4'd0, 4'd0, 4'd5, 4'd5}, {8'h00, 8'h00, 8'h00, 8'h3C}, 4'b0001, 1'b1); tick();
        apply("rw2", 4'b0010, 4'b0000, {4'd0, 4'd0, 4'd5, 4'd0}, '0, 4'b0010, 1'b1); tick();
`else
        apply("rw", 4'b0011, 4'b0001, {4'd0, 4'd0, 4'd5, 4'd5}, {8'h00, 8'h00, 8'h00, 8'h3C}, 4'b0011, 1'b0); tick();
`endif
        apply("rb5", 4'b0001, 4'b0000, {4'd0, 4'd0, 4'd0, 4'd5}, '0, 4'b0001, 1'b1); tick();

        // Read granted, then reset raised before its data would be returned.
        apply("pend", 4'b0100, 4'b0000, {4'd0, 4'd2, 4'd0, 4'd0}, '0, 4'b0100, 1'b1);
        void'(sb.pop_back());
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        cycle_n++;
        chk("pend rsp_valid", 64'(response_valid), 64'(0));
        chk("pend ready in reset", 64'(request_ready), 64'(0));
        @(negedge clock);
        request_valid = '0;
        tick();
        reset = 1'b0;

        apply("post", 4'b1111, 4'b0000, RR_ADDR, '0, 4'b0011, 1'b1); tick();
        request_valid = '0;
        tick();
        chk("sb drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
